lio_i8080_bus_engine: RTL and testbench

// Parametrised i8080 (8080-style MCU LCD) bus timing engine; next generation of the lio_i8080 PHY.

---
 rtl/lio_i8080_bus_engine_if.sv | 48 ++++
 rtl/lio_i8080_bus_engine.sv | 187 ++++++++++++++++++
 tb/tb_lio_i8080_bus_engine.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/lio_i8080_bus_engine_if.sv
// Request/response stream and i8080 pad-side signals for lio_i8080_bus_engine.
// LIO_I8080_TE_SYNC_EN adds the req_te_sync request field.
interface lio_i8080_bus_engine_if #(
  parameter int unsigned IF_DATA_SIZE = 16,
  parameter int unsigned NUM_CS       = 1
);
  localparam int unsigned CS_W = $clog2(NUM_CS) + 1;

  logic                    req_valid;
  logic                    req_ready;
  logic                    req_rd;
  logic                    req_dc;
  logic [CS_W-1:0]         req_cs;
  logic                    req_last;
  logic [IF_DATA_SIZE-1:0] req_data;
`ifdef LIO_I8080_TE_SYNC_EN
  logic                    req_te_sync;
`endif
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [IF_DATA_SIZE-1:0] rsp_data;
  logic [NUM_CS-1:0]       CSn;
  logic                    DC;
  logic                    WR;
  logic                    RD;
  logic                    OE;
  logic [IF_DATA_SIZE-1:0] DO;
  logic [IF_DATA_SIZE-1:0] DI;
  logic                    TE;

  // Environment side: front end plus pad inputs.
  modport master (
`ifdef LIO_I8080_TE_SYNC_EN
    output req_te_sync,
`endif
    output req_valid, req_rd, req_dc, req_cs, req_last, req_data, rsp_ready, DI, TE,
    input  req_ready, rsp_valid, rsp_data, CSn, DC, WR, RD, OE, DO
  );

  // Bus engine side.
  modport slave (
`ifdef LIO_I8080_TE_SYNC_EN
    input  req_te_sync,
`endif
    input  req_valid, req_rd, req_dc, req_cs, req_last, req_data, rsp_ready, DI, TE,
    output req_ready, rsp_valid, rsp_data, CSn, DC, WR, RD, OE, DO
  );
endinterface

// File: rtl/lio_i8080_bus_engine.sv
// i8080 bus timing engine: request stream -> CSn/DC/WR/RD/OE/DO strobes, read data -> response stream.
// Define LIO_I8080_TE_SYNC_EN to enable tearing-effect synchronised transfers (TE_WAIT state).
module lio_i8080_bus_engine #(
  parameter int unsigned IF_DATA_SIZE = 16,
  parameter int unsigned NUM_CS       = 1,
  parameter int unsigned TIMING_W     = 4
) (
  input  logic                 aclk,
  input  logic                 arst,
  input  logic [TIMING_W-1:0]  cfg_setup,
  input  logic [TIMING_W-1:0]  cfg_strobe,
  input  logic [TIMING_W-1:0]  cfg_hold,
  output logic                 busy,
  lio_i8080_bus_engine_if.slave bus
);
  localparam int unsigned CS_W = $clog2(NUM_CS) + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_GAP,
`ifdef LIO_I8080_TE_SYNC_EN
    ST_TE_WAIT,
`endif
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_t;

  state_t              state;
  logic [TIMING_W-1:0] cnt;
  logic [TIMING_W-1:0] setup_q, strobe_q, hold_q;
  logic                rd_q, last_q;
  logic [CS_W-1:0]     cs_q;

  logic                accept_c, gap_c, launch_c, strobe_end_c, xfer_end_c;
  logic                idle_nx_c, rsp_valid_nx_c, cs_low_nx_c, rd_sel_c;
  logic [TIMING_W-1:0] setup_sel_c, strobe_sel_c;

`ifdef LIO_I8080_TE_SYNC_EN
  logic [1:0] te_sync;
  logic       te_prev, te_q, te_rise_c;
  assign te_rise_c = te_sync[1] & ~te_prev;
`else
  logic unused_te;
  assign unused_te = bus.TE;
`endif

  // Active-low one-hot select; out-of-range index selects nothing.
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] idx);
    logic [NUM_CS-1:0] m;
    m = '1;
    for (int unsigned i = 0; i < NUM_CS; i++)
      if (idx == CS_W'(i)) m[i] = 1'b0;
    return m;
  endfunction

  always_comb begin
    accept_c       = bus.req_valid & bus.req_ready;
    gap_c          = (~&bus.CSn) && (bus.req_cs != cs_q);
    strobe_end_c   = (state == ST_STROBE) && (cnt == '0);
    xfer_end_c     = (strobe_end_c && (hold_q == '0)) || ((state == ST_HOLD) && (cnt == '0));
    idle_nx_c      = ((state == ST_IDLE) && !accept_c) || xfer_end_c;
    rsp_valid_nx_c = (strobe_end_c & rd_q) | (bus.rsp_valid & ~bus.rsp_ready);
    cs_low_nx_c    = xfer_end_c ? (~last_q & ~&bus.CSn) : ~&bus.CSn;
    // Timing comes straight from cfg on the accept edge, from the latched copy afterwards.
    setup_sel_c    = (state == ST_IDLE) ? cfg_setup  : setup_q;
    strobe_sel_c   = (state == ST_IDLE) ? cfg_strobe : strobe_q;
    rd_sel_c       = (state == ST_IDLE) ? bus.req_rd : rd_q;
    launch_c       = 1'b0;
    case (state)
`ifdef LIO_I8080_TE_SYNC_EN
      ST_IDLE:    launch_c = accept_c & ~gap_c & ~bus.req_te_sync;
      ST_CS_GAP:  launch_c = ~te_q;
      ST_TE_WAIT: launch_c = te_rise_c;
`else
      ST_IDLE:    launch_c = accept_c & ~gap_c;
      ST_CS_GAP:  launch_c = 1'b1;
`endif
      default:    launch_c = 1'b0;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      setup_q       <= '0;
      strobe_q      <= '0;
      hold_q        <= '0;
      rd_q          <= 1'b0;
      last_q        <= 1'b0;
      cs_q          <= '0;
      bus.CSn       <= '1;
      bus.WR        <= 1'b1;
      bus.RD        <= 1'b1;
      bus.OE        <= 1'b0;
      bus.DC        <= 1'b0;
      bus.DO        <= IF_DATA_SIZE'(0);
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= IF_DATA_SIZE'(0);
      bus.req_ready <= 1'b0;
      busy          <= 1'b0;
`ifdef LIO_I8080_TE_SYNC_EN
      te_sync       <= '0;
      te_prev       <= 1'b0;
      te_q          <= 1'b0;
`endif
    end else begin
      bus.rsp_valid <= rsp_valid_nx_c;
      bus.req_ready <= idle_nx_c & ~rsp_valid_nx_c;
      busy          <= ~idle_nx_c | cs_low_nx_c;
`ifdef LIO_I8080_TE_SYNC_EN
      te_sync       <= {te_sync[0], bus.TE};
      te_prev       <= te_sync[1];
`endif
      case (state)
        ST_IDLE: if (accept_c) begin
          setup_q  <= cfg_setup;
          strobe_q <= cfg_strobe;
          hold_q   <= cfg_hold;
          rd_q     <= bus.req_rd;
          last_q   <= bus.req_last;
          cs_q     <= bus.req_cs;
          bus.DC   <= bus.req_dc;
          bus.DO   <= bus.req_data;
          bus.OE   <= ~bus.req_rd;
`ifdef LIO_I8080_TE_SYNC_EN
          te_q     <= bus.req_te_sync;
`endif
          if (gap_c) begin
            state   <= ST_CS_GAP;
            bus.CSn <= '1;
          end else begin
            bus.CSn <= cs_decode(bus.req_cs);
`ifdef LIO_I8080_TE_SYNC_EN
            if (bus.req_te_sync) state <= ST_TE_WAIT;
`endif
          end
        end
        ST_CS_GAP: begin
          bus.CSn <= cs_decode(cs_q);
`ifdef LIO_I8080_TE_SYNC_EN
          if (te_q) state <= ST_TE_WAIT;
`endif
        end
        ST_SETUP: if (cnt == '0) begin
          state  <= ST_STROBE;
          cnt    <= strobe_q;
          bus.WR <= rd_q;
          bus.RD <= ~rd_q;
        end else begin
          cnt <= cnt - TIMING_W'(1);
        end
        ST_STROBE: if (cnt == '0) begin
          bus.WR <= 1'b1;
          bus.RD <= 1'b1;
          if (rd_q) bus.rsp_data <= bus.DI;
          if (hold_q != '0) begin
            state <= ST_HOLD;
            cnt   <= hold_q - TIMING_W'(1);
          end
        end else begin
          cnt <= cnt - TIMING_W'(1);
        end
        ST_HOLD: if (cnt != '0) cnt <= cnt - TIMING_W'(1);
        default: ;
      endcase
      // Start of the SETUP/STROBE sequence, shared by accept, CS gap and TE wait.
      if (launch_c) begin
        if (setup_sel_c != '0) begin
          state <= ST_SETUP;
          cnt   <= setup_sel_c - TIMING_W'(1);
        end else begin
          state  <= ST_STROBE;
          cnt    <= strobe_sel_c;
          bus.WR <= rd_sel_c;
          bus.RD <= ~rd_sel_c;
        end
      end
      if (xfer_end_c) begin
        state  <= ST_IDLE;
        bus.OE <= 1'b0;
        if (last_q) bus.CSn <= '1;
      end
    end
  end
endmodule

// File: tb/tb_lio_i8080_bus_engine.sv
// Self-checking bench for lio_i8080_bus_engine: directed cases plus randomized transfers
// checked cycle by cycle against a transfer-level timing model.
`timescale 1ns/1ps
module tb_lio_i8080_bus_engine;
  localparam int unsigned DW  = 16;
  localparam int unsigned NCS = 2;
  localparam int unsigned TW  = 4;
  localparam int unsigned CSW = $clog2(NCS) + 1;

  logic          aclk = 1'b0;
  logic          arst;
  logic [TW-1:0] cfg_setup, cfg_strobe, cfg_hold;
  logic          busy;

  lio_i8080_bus_engine_if #(.IF_DATA_SIZE(DW), .NUM_CS(NCS)) bus ();

  lio_i8080_bus_engine #(.IF_DATA_SIZE(DW), .NUM_CS(NCS), .TIMING_W(TW)) dut (
    .aclk       (aclk),
    .arst       (arst),
    .cfg_setup  (cfg_setup),
    .cfg_strobe (cfg_strobe),
    .cfg_hold   (cfg_hold),
    .busy       (busy),
    .bus        (bus)
  );

  always #5 aclk = ~aclk;

  int n_chk  = 0;
  int n_fail = 0;
  int cs_held = -1;   // chip select the model believes is held low, -1 if none

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [NCS-1:0] cs_mask(input int cs);
    logic [NCS-1:0] m;
    m = '1;
    if (cs >= 0 && cs < NCS) m[cs] = 1'b0;
    return m;
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 40) begin
      @(negedge aclk);
      n++;
    end
    check("req_ready_wait", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic drive_req(input bit rd, input bit dc, input int cs, input bit last,
                           input logic [DW-1:0] data, input int su, input int st, input int ho);
    bus.req_valid = 1'b1;
    bus.req_rd    = rd;
    bus.req_dc    = dc;
    bus.req_cs    = CSW'(cs);
    bus.req_last  = last;
    bus.req_data  = data;
    cfg_setup     = TW'(su);
    cfg_strobe    = TW'(st);
    cfg_hold      = TW'(ho);
    bus.DI        = DW'($urandom);
`ifdef LIO_I8080_TE_SYNC_EN
    bus.req_te_sync = 1'b0;
`endif
  endtask

  // One complete transfer, checked every cycle from accept to the following idle cycle.
  task automatic xfer(input bit rd, input bit dc, input int cs, input bit last,
                      input logic [DW-1:0] data, input int su, input int st, input int ho,
                      input int rdly);
    int g, s0, se, tot;
    logic [DW-1:0] rdata;
    wait_ready();
    g     = (cs_held >= 0 && cs != cs_held) ? 1 : 0;
    s0    = g + su + 1;
    se    = s0 + st;
    tot   = se + ho;
    rdata = DW'($urandom);
    drive_req(rd, dc, cs, last, data, su, st, ho);
    bus.TE = 1'($urandom);
    for (int k = 1; k <= tot; k++) begin
      @(negedge aclk);
      if (k == 1) begin
        bus.req_valid = 1'b0;
        cfg_setup  = TW'($urandom);
        cfg_strobe = TW'($urandom);
        cfg_hold   = TW'($urandom);
      end
      check("csn",       32'(bus.CSn), 32'((k <= g) ? {NCS{1'b1}} : cs_mask(cs)));
      check("wr",        32'(bus.WR), 32'(!(!rd && k >= s0 && k <= se)));
      check("rd",        32'(bus.RD), 32'(!(rd && k >= s0 && k <= se)));
      check("oe",        32'(bus.OE), 32'(!rd));
      check("dc",        32'(bus.DC), 32'(dc));
      check("do",        32'(bus.DO), 32'(data));
      check("busy",      32'(busy), 32'd1);
      check("req_ready", 32'(bus.req_ready), 32'd0);
      check("rsp_valid", 32'(bus.rsp_valid), 32'(rd && k > se));
      if (rd && k > se) check("rsp_data", 32'(bus.rsp_data), 32'(rdata));
      if (k == se) bus.DI = rdata;
      else if (k == se + 1) bus.DI = DW'($urandom);
    end
    @(negedge aclk);
    check("idle_csn",       32'(bus.CSn), 32'(last ? {NCS{1'b1}} : cs_mask(cs)));
    check("idle_wr",        32'(bus.WR), 32'd1);
    check("idle_rd",        32'(bus.RD), 32'd1);
    check("idle_oe",        32'(bus.OE), 32'd0);
    check("idle_busy",      32'(busy), 32'(!last && cs < NCS));
    check("idle_rsp_valid", 32'(bus.rsp_valid), 32'(rd));
    check("idle_req_ready", 32'(bus.req_ready), 32'(!rd));
    cs_held = (!last && cs < NCS) ? cs : -1;
    bus.DI = DW'($urandom);
    if (rd) begin
      check("rsp_data", 32'(bus.rsp_data), 32'(rdata));
      for (int d = 0; d < rdly; d++) begin
        @(negedge aclk);
        check("rsp_stall_valid", 32'(bus.rsp_valid), 32'd1);
        check("rsp_stall_ready", 32'(bus.req_ready), 32'd0);
        check("rsp_stall_data",  32'(bus.rsp_data), 32'(rdata));
      end
      bus.rsp_ready = 1'b1;
      bus.req_valid = 1'b1;   // competing request in the handshake cycle must not be taken
      @(negedge aclk);
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b0;
      check("rsp_done_valid", 32'(bus.rsp_valid), 32'd0);
      check("rsp_done_ready", 32'(bus.req_ready), 32'd1);
    end
  endtask

  task automatic reset_mid_strobe();
    wait_ready();
    drive_req(1'b1, 1'b1, 0, 1'b0, 16'h5A5A, 0, 3, 0);
    @(negedge aclk);
    bus.req_valid = 1'b0;
    check("mid_rd_low", 32'(bus.RD), 32'd0);
    arst = 1'b1;
    @(negedge aclk);
    arst = 1'b0;
    check("rst_wr",        32'(bus.WR), 32'd1);
    check("rst_rd",        32'(bus.RD), 32'd1);
    check("rst_csn",       32'(bus.CSn), 32'({NCS{1'b1}}));
    check("rst_oe",        32'(bus.OE), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge aclk);
    check("post_rst_ready", 32'(bus.req_ready), 32'd1);
    check("post_rst_rsp",   32'(bus.rsp_valid), 32'd0);
    cs_held = -1;
  endtask

`ifdef LIO_I8080_TE_SYNC_EN
  task automatic te_test();
    wait_ready();
    drive_req(1'b0, 1'b1, 0, 1'b1, 16'hBEEF, 0, 1, 0);
    bus.TE = 1'b0;
    bus.req_te_sync = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge aclk);
      bus.req_valid = 1'b0;
      bus.req_te_sync = 1'b0;
      check("te_wait_wr",  32'(bus.WR), 32'd1);
      check("te_wait_csn", 32'(bus.CSn), 32'(cs_mask(0)));
      check("te_wait_do",  32'(bus.DO), 32'h0000BEEF);
    end
    bus.TE = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge aclk);
      check("te_wr", 32'(bus.WR), 32'(!(k == 3 || k == 4)));
    end
    check("te_end_csn",   32'(bus.CSn), 32'({NCS{1'b1}}));
    check("te_end_ready", 32'(bus.req_ready), 32'd1);
    bus.TE = 1'b0;
  endtask
`endif

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    arst = 1'b1;
    bus.req_valid = 1'b0; bus.req_rd = 1'b0; bus.req_dc = 1'b0; bus.req_cs = '0;
    bus.req_last = 1'b0; bus.req_data = '0; bus.rsp_ready = 1'b0; bus.DI = '0; bus.TE = 1'b0;
`ifdef LIO_I8080_TE_SYNC_EN
    bus.req_te_sync = 1'b0;
`endif
    cfg_setup = '0; cfg_strobe = '0; cfg_hold = '0;
    repeat (3) @(negedge aclk);
    check("reset_csn",       32'(bus.CSn), 32'({NCS{1'b1}}));
    check("reset_wr",        32'(bus.WR), 32'd1);
    check("reset_rd",        32'(bus.RD), 32'd1);
    check("reset_oe",        32'(bus.OE), 32'd0);
    check("reset_dc",        32'(bus.DC), 32'd0);
    check("reset_do",        32'(bus.DO), 32'd0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_data",  32'(bus.rsp_data), 32'd0);
    check("reset_busy",      32'(busy), 32'd0);
    check("reset_req_ready", 32'(bus.req_ready), 32'd0);
    arst = 1'b0;
    @(negedge aclk);
    check("first_req_ready", 32'(bus.req_ready), 32'd1);

    xfer(1'b0, 1'b1, 0, 1'b1, 16'hA5C3, 1, 1, 1, 0);      // basic write
    xfer(1'b1, 1'b0, 0, 1'b1, 16'h0000, 0, 2, 0, 4);      // read with stalled response
    xfer(1'b0, 1'b1, 0, 1'b0, 16'h1111, 0, 0, 0, 0);      // burst on cs0
    xfer(1'b0, 1'b1, 0, 1'b0, 16'h2222, 1, 0, 1, 0);
    xfer(1'b0, 1'b1, 0, 1'b1, 16'h3333, 0, 1, 0, 0);
    xfer(1'b0, 1'b0, 0, 1'b0, 16'h4444, 0, 0, 0, 0);      // cs0 -> cs1 switch
    xfer(1'b0, 1'b1, 1, 1'b0, 16'h5555, 0, 0, 0, 0);
    xfer(1'b0, 1'b1, 3, 1'b1, 16'h6666, 1, 1, 0, 0);      // out-of-range cs while cs1 held
    xfer(1'b0, 1'b1, 2, 1'b0, 16'h7777, 0, 0, 0, 0);
    xfer(1'b0, 1'b1, 15, 1'b1, 16'hFFFF, 15, 15, 15, 0);  // widest timing fields
    xfer(1'b1, 1'b1, 1, 1'b1, 16'h0000, 2, 1, 2, 0);      // read with hold
    reset_mid_strobe();
`ifdef LIO_I8080_TE_SYNC_EN
    repeat (4) @(negedge aclk);
    te_test();
`endif
    for (int t = 0; t < 60; t++) begin
      xfer(1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom),
           DW'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
